// File: rtl/midi_note_rx.sv
// MIDI receiver: 2-flop sync, UART deframer, running-status parser, note events.
// Latency: event pulse rises 2 clocks after the edge that samples the final stop bit.
// Backpressure: none; events are single-cycle pulses that the consumer must take.
module midi_note_rx #(
   parameter int CLK_HZ         = 65000000,
   parameter int BAUD           = 31250,
   parameter int CHANNEL_FILTER = 0,
   parameter int CHANNEL        = 0
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       serial,
   output logic       ready,
   output logic       note_off,
   output logic [6:0] key_index,
   output logic [6:0] velocity,
   output logic       frame_err
);

   localparam int          BIT_CYCLES = CLK_HZ / BAUD;
   localparam logic [11:0] BIT_LOAD   = 12'(BIT_CYCLES - 1);
   localparam logic [11:0] HALF_LOAD  = 12'(BIT_CYCLES / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   // synchronizer
   logic       sync1_q, s_q;
   // byte deframer
   rx_state_t  state_q;
   logic [11:0] cnt_q;
   logic [2:0] idx_q;
   logic [7:0] shift_q;
   logic       byte_vld_q;
   logic       ferr_pulse_q;
   logic       frame_err_q;
   // parser
   logic       rs_vld_q, rs_ign_q, dcnt_q;
   logic [3:0] rs_type_q;
   logic [6:0] d1_q;
   logic       evt_on_q, evt_off_q;
   logic [6:0] evt_key_q, evt_vel_q;
   // outputs
   logic       ready_q, note_off_q;
   logic [6:0] key_q, vel_q;

   logic       ign_d;
   logic       two_byte_d;

   // A status byte is flagged "ignore" when filtering is on and its channel differs.
   assign ign_d      = (CHANNEL_FILTER != 0) && (shift_q[3:0] != 4'(CHANNEL));
   assign two_byte_d = rs_type_q inside {4'h8, 4'h9, 4'hA, 4'hB, 4'hE};

   // Bring the asynchronous line into the clock domain; idles high out of reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         s_q     <= 1'b1;
      end else begin
         sync1_q <= serial;
         s_q     <= sync1_q;
      end
   end

   // UART deframer: mid-bit sampling, LSB first; returns to IDLE right after the stop sample
   // so the next start edge can be caught within the remaining half bit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         byte_vld_q   <= 1'b0;
         ferr_pulse_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         byte_vld_q   <= 1'b0;
         ferr_pulse_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!s_q) begin
                  state_q <= START;
                  cnt_q   <= HALF_LOAD;
               end
            end
            START: begin
               if (cnt_q == 12'd0) begin
                  if (s_q) begin
                     state_q <= IDLE;
                  end else begin
                     state_q <= DATA;
                     cnt_q   <= BIT_LOAD;
                     idx_q   <= 3'd0;
                  end
               end else begin
                  cnt_q <= cnt_q - 12'd1;
               end
            end
            DATA: begin
               if (cnt_q == 12'd0) begin
                  shift_q <= {s_q, shift_q[7:1]};
                  cnt_q   <= BIT_LOAD;
                  if (idx_q == 3'd7) state_q <= STOP;
                  else               idx_q   <= idx_q + 3'd1;
               end else begin
                  cnt_q <= cnt_q - 12'd1;
               end
            end
            STOP: begin
               if (cnt_q == 12'd0) begin
                  state_q <= IDLE;
                  if (s_q) begin
                     byte_vld_q <= 1'b1;
                  end else begin
                     frame_err_q  <= 1'b1;
                     ferr_pulse_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - 12'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Message parser with running status; shift_q holds the completed byte while byte_vld_q is high.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rs_vld_q  <= 1'b0;
         rs_ign_q  <= 1'b0;
         rs_type_q <= '0;
         dcnt_q    <= 1'b0;
         d1_q      <= '0;
         evt_on_q  <= 1'b0;
         evt_off_q <= 1'b0;
         evt_key_q <= '0;
         evt_vel_q <= '0;
      end else begin
         evt_on_q  <= 1'b0;
         evt_off_q <= 1'b0;
         if (ferr_pulse_q) begin
            rs_vld_q <= 1'b0;
            dcnt_q   <= 1'b0;
         end else if (byte_vld_q && (shift_q[7:3] != 5'b11111)) begin
            if (shift_q[7:4] == 4'hF) begin
               rs_vld_q <= 1'b0;
               dcnt_q   <= 1'b0;
            end else if (shift_q[7]) begin
               rs_type_q <= shift_q[7:4];
               rs_vld_q  <= 1'b1;
               rs_ign_q  <= ign_d;
               dcnt_q    <= 1'b0;
            end else if (rs_vld_q) begin
               if (!two_byte_d) begin
                  dcnt_q <= 1'b0;
               end else if (!dcnt_q) begin
                  d1_q   <= shift_q[6:0];
                  dcnt_q <= 1'b1;
               end else begin
                  dcnt_q <= 1'b0;
                  if (!rs_ign_q) begin
                     if ((rs_type_q == 4'h9) && (shift_q[6:0] != 7'd0)) begin
                        evt_on_q  <= 1'b1;
                        evt_key_q <= d1_q;
                        evt_vel_q <= shift_q[6:0];
                     end else if ((rs_type_q == 4'h9) || (rs_type_q == 4'h8)) begin
                        evt_off_q <= 1'b1;
                        evt_key_q <= d1_q;
                        evt_vel_q <= 7'd0;
                     end
                  end
               end
            end
         end
      end
   end

   // Registered event outputs; key and velocity hold until the next event.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ready_q    <= 1'b0;
         note_off_q <= 1'b0;
         key_q      <= '0;
         vel_q      <= '0;
      end else begin
         ready_q    <= evt_on_q;
         note_off_q <= evt_off_q;
         if (evt_on_q || evt_off_q) begin
            key_q <= evt_key_q;
            vel_q <= evt_vel_q;
         end
      end
   end

   assign ready     = ready_q;
   assign note_off  = note_off_q;
   assign key_index = key_q;
   assign velocity  = vel_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_midi_note_rx.sv
// Bench for midi_note_rx: two instances (unfiltered, channel-0 filtered) share one serial line.
// Directed test-plan sequences followed by a random byte stream, checked against a message-level model.
module tb_midi_note_rx;

   localparam int BAUD   = 31250;
   localparam int CLK_HZ = BAUD * 20;
   localparam int B      = CLK_HZ / BAUD;
   localparam int H      = B / 2;
   // sync (2) + IDLE detect (1) + half bit + 9 bits to stop sample + 2 pipeline clocks
   localparam int LAT    = 3 + H + 9 * B + 2;

   typedef struct packed {
      logic [1:0]  kind;   // 1 = note-on, 2 = note-off
      logic [6:0]  key;
      logic [6:0]  vel;
      logic [31:0] cyc;
   } ev_t;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       serial;
   logic       rdy0, off0, ferr0, rdy1, off1, ferr1;
   logic [6:0] key0, vel0, key1, vel1;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [31:0] cyc = 0;

   ev_t exp0[$], exp1[$], obs0[$], obs1[$];

   // reference model state, index 0 = unfiltered, 1 = channel 0 only
   bit  m_vld [2];
   bit  m_ign [2];
   int  m_type[2];
   int  m_n   [2];
   int  m_b1  [2];
   int  m_key [2];
   int  m_vel [2];
   bit  m_ferr;

   midi_note_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL_FILTER(0), .CHANNEL(0)) u_dut (
      .clock(clock), .reset_n(reset_n), .serial(serial),
      .ready(rdy0), .note_off(off0), .key_index(key0), .velocity(vel0), .frame_err(ferr0));

   midi_note_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL_FILTER(1), .CHANNEL(0)) u_dut_f (
      .clock(clock), .reset_n(reset_n), .serial(serial),
      .ready(rdy1), .note_off(off1), .key_index(key1), .velocity(vel1), .frame_err(ferr1));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Record every event pulse seen on either instance.
   always @(negedge clock) begin
      if (rdy0 || off0) begin
         chk("excl0", {31'd0, rdy0 & off0}, 32'd0);
         obs0.push_back(ev_t'{rdy0 ? 2'd1 : 2'd2, key0, vel0, cyc});
      end
      if (rdy1 || off1) begin
         chk("excl1", {31'd0, rdy1 & off1}, 32'd0);
         obs1.push_back(ev_t'{rdy1 ? 2'd1 : 2'd2, key1, vel1, cyc});
      end
   end

   task automatic model_reset();
      for (int f = 0; f < 2; f++) begin
         m_vld[f] = 0; m_ign[f] = 0; m_type[f] = 0; m_n[f] = 0;
         m_b1[f] = 0; m_key[f] = 0; m_vel[f] = 0;
      end
      m_ferr = 0;
   endtask

   task automatic push_ev(input int f, input ev_t e);
      if (f == 0) exp0.push_back(e);
      else        exp1.push_back(e);
      m_key[f] = e.key;
      m_vel[f] = e.vel;
   endtask

   // Message-level interpretation of one received byte (st = its start-bit cycle).
   task automatic model_byte(input int b, input bit ok, input logic [31:0] st);
      int need;
      if (!ok) begin
         m_ferr = 1;
         for (int f = 0; f < 2; f++) begin m_vld[f] = 0; m_n[f] = 0; end
         return;
      end
      for (int f = 0; f < 2; f++) begin
         if (b >= 'hF8) begin
            // realtime: invisible
         end else if (b >= 'hF0) begin
            m_vld[f] = 0; m_n[f] = 0;
         end else if (b >= 'h80) begin
            m_type[f] = b / 16;
            m_vld[f]  = 1;
            m_ign[f]  = (f == 1) && ((b % 16) != 0);
            m_n[f]    = 0;
         end else if (m_vld[f]) begin
            need = (m_type[f] == 'hC || m_type[f] == 'hD) ? 1 : 2;
            if (m_n[f] == 0) m_b1[f] = b;
            m_n[f]++;
            if (m_n[f] == need) begin
               m_n[f] = 0;
               if (need == 2 && !m_ign[f]) begin
                  if (m_type[f] == 9 && b != 0)
                     push_ev(f, ev_t'{2'd1, 7'(m_b1[f]), 7'(b), st + LAT});
                  else if (m_type[f] == 9 || m_type[f] == 8)
                     push_ev(f, ev_t'{2'd2, 7'(m_b1[f]), 7'd0, st + LAT});
               end
            end
         end
      end
   endtask

   // Drive one UART frame; caller is aligned to a posedge, and so is the return.
   task automatic send_byte(input int b, input bit ok);
      logic [31:0] st;
      logic [7:0]  d;
      d = 8'(b);
      #1 serial = 1'b0;
      st = cyc;
      repeat (B) @(posedge clock);
      for (int i = 0; i < 8; i++) begin
         #1 serial = d[i];
         repeat (B) @(posedge clock);
      end
      #1 serial = ok;
      if (ok) begin
         repeat (B) @(posedge clock);
      end else begin
         repeat (H + 4) @(posedge clock);
         #1 serial = 1'b1;
         repeat (2 * B) @(posedge clock);
      end
      model_byte(b, ok, st);
   endtask

   task automatic send_seq(input int bytes[$]);
      foreach (bytes[i]) send_byte(bytes[i], 1'b1);
      repeat (8) @(posedge clock);
   endtask

   task automatic cmp_events(input string seg);
      int   ne, no;
      ev_t  e, o;
      for (int f = 0; f < 2; f++) begin
         ne = (f == 0) ? exp0.size() : exp1.size();
         no = (f == 0) ? obs0.size() : obs1.size();
         chk($sformatf("%s/i%0d/n_ev", seg, f), no, ne);
         for (int i = 0; i < ne && i < no; i++) begin
            e = (f == 0) ? exp0[i] : exp1[i];
            o = (f == 0) ? obs0[i] : obs1[i];
            chk($sformatf("%s/i%0d/ev%0d/kind", seg, f, i), o.kind, e.kind);
            chk($sformatf("%s/i%0d/ev%0d/key", seg, f, i), o.key, e.key);
            chk($sformatf("%s/i%0d/ev%0d/vel", seg, f, i), o.vel, e.vel);
            chk($sformatf("%s/i%0d/ev%0d/cyc", seg, f, i), o.cyc, e.cyc);
         end
         chk($sformatf("%s/i%0d/key_index", seg, f), (f == 0) ? key0 : key1, m_key[f]);
         chk($sformatf("%s/i%0d/velocity", seg, f), (f == 0) ? vel0 : vel1, m_vel[f]);
         chk($sformatf("%s/i%0d/frame_err", seg, f), (f == 0) ? ferr0 : ferr1, m_ferr);
      end
      exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
   endtask

   task automatic chk_zero_outputs(input string seg);
      chk({seg, "/ready"}, {rdy0, rdy1}, 0);
      chk({seg, "/note_off"}, {off0, off1}, 0);
      chk({seg, "/key_index"}, {key0, key1}, 0);
      chk({seg, "/velocity"}, {vel0, vel1}, 0);
      chk({seg, "/frame_err"}, {ferr0, ferr1}, 0);
   endtask

   initial begin
      int r, b, ch;
      bit ok;
      model_reset();
      reset_n = 1'b0;
      serial  = 1'b1;
      repeat (3) @(posedge clock);
      #2 chk_zero_outputs("reset");
      @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (4 * B) @(posedge clock);

      // basic note-on
      send_seq('{'h90, 'h3C, 'h64});
      cmp_events("note_on");

      // running status: note-on then velocity-0 note-off
      send_seq('{'h90, 'h3C, 'h64, 'h40, 'h00});
      cmp_events("running");

      // realtime byte inside a message, then a system byte kills running status
      send_seq('{'h90, 'h3C, 'hF8, 'h64});
      send_seq('{'hF0, 'h3C, 'h64});
      cmp_events("realtime_sys");

      // start-bit glitch shorter than half a bit
      #1 serial = 1'b0;
      repeat (H / 2) @(posedge clock);
      #1 serial = 1'b1;
      repeat (3 * B) @(posedge clock);
      cmp_events("glitch");

      // bad stop bit: sticky frame_err, running status cleared
      send_byte('h80, 1'b1);
      send_byte('h30, 1'b0);
      send_seq('{'h30, 'h00});
      cmp_events("frame_err");

      // channel filter: channel 1 ignored by the filtered instance only
      send_seq('{'h91, 'h3C, 'h64});
      send_seq('{'h90, 'h3C, 'h64});
      cmp_events("filter");

      // random stream with random idle gaps (including none)
      for (int n = 0; n < 60; n++) begin
         r  = $urandom_range(0, 99);
         ch = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
         if      (r < 15) b = 'h90 + ch;
         else if (r < 22) b = 'h80 + ch;
         else if (r < 28) b = 'h80 + $urandom_range(0, 'h6F);
         else if (r < 31) b = 'hF8 + $urandom_range(0, 7);
         else if (r < 33) b = 'hF0 + $urandom_range(0, 7);
         else if (r < 45) b = 0;
         else             b = $urandom_range(0, 127);
         ok = ($urandom_range(0, 99) >= 3);
         send_byte(b, ok);
         if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 40)) @(posedge clock);
         if (n % 20 == 19) begin
            repeat (8) @(posedge clock);
            cmp_events($sformatf("random%0d", n / 20));
         end
      end

      // reset during the data bits of a velocity byte
      send_seq('{'h90, 'h3C, 'h64});
      cmp_events("pre_reset");
      send_byte('h45, 1'b1);
      #1 serial = 1'b0;
      repeat (B) @(posedge clock);
      #1 serial = 1'b1;
      repeat (B + H) @(posedge clock);
      #1 reset_n = 1'b0;
      #2 chk_zero_outputs("async_reset");
      serial = 1'b1;
      model_reset();
      exp0.delete(); exp1.delete();
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (2 * B) @(posedge clock);
      send_seq('{'h90, 'h45, 'h7F});
      cmp_events("post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/midi_note_rx.md
Name: midi_note_rx

Overview:
- Serial MIDI front end: receives the 31250-baud MIDI stream from the keyboard pin, deframes UART bytes, and parses channel-voice messages with running status.
- Emits one-cycle note-on / note-off events carrying key index and velocity.
- Feeds game_logic's midi_index/midi_ready inputs in the clock_65mhz domain, replacing the bare byte receiver.

Parameters:
- CLK_HZ, 65000000, system clock frequency in Hz.
- BAUD, 31250, serial bit rate.
- BIT_CYCLES, CLK_HZ/BAUD (2080), clocks per bit; derived, not overridden.
- CHANNEL_FILTER, 0, 1 = accept only channel CHANNEL; 0 = accept all channels.
- CHANNEL, 0, MIDI channel 0-15 used when CHANNEL_FILTER=1.

Ports:
- clock, input, 1, system clock (clock_65mhz).
- reset_n, input, 1, asynchronous active-low reset.
- serial, input, 1, raw MIDI line (idle high), asynchronous to clock.
- ready, output, 1, one-cycle pulse: note-on event valid.
- note_off, output, 1, one-cycle pulse: note-off event valid.
- key_index, output, 7, key number of the last event.
- velocity, output, 7, velocity of the last event (0 for note-off).
- frame_err, output, 1, sticky: set on a bad stop bit; cleared only by reset.

Behaviour:
- Reset, asserted asynchronously:
  - All state clears: ready=0, note_off=0, key_index=0, velocity=0, frame_err=0.
  - Running status invalid; byte FSM in IDLE.
  - Synchronizer flops preset to 1.
- Input synchronization: serial passes through a 2-flop synchronizer; all logic uses the synchronized value s.
- Byte FSM (states IDLE, START, DATA, STOP), one bit counter (12 bits), one bit index (3 bits):
  - IDLE: on s==0, go to START and load the counter.
  - START: after BIT_CYCLES/2 (1040) clocks, sample s.
    - s==1 is a glitch: go to IDLE, no byte.
    - Otherwise go to DATA.
  - DATA: sample every BIT_CYCLES clocks, LSB first, 8 samples, then go to STOP.
  - STOP: sample after BIT_CYCLES clocks.
    - s==1: byte_valid pulses on the next cycle.
    - s==0: set frame_err, discard the byte, clear running status.
    - Either way return to IDLE immediately. The next start edge may begin in the half-bit remaining.
- Parser, advanced on byte_valid:
  - Realtime bytes 0xF8-0xFF: ignored completely; partial-message state is untouched.
  - System bytes 0xF0-0xF7: clear running status and the partial message.
  - Status bytes 0x80-0xEF:
    - Latch type (high nibble) and channel; mark running status valid; data count = 0.
    - Any partial message is abandoned.
    - If CHANNEL_FILTER=1 and the channel does not match, running status is valid but flagged "ignore".
  - Data bytes 0x00-0x7F with no valid running status: dropped.
  - Types 0xC and 0xD: one data byte, consumed silently.
  - Types 0x8, 0x9, 0xA, 0xB, 0xE: two data bytes.
    - First data byte is held.
    - The second completes the message and resets data count to 0, so running status allows repeats.
- Event generation, on completion of a non-ignored message:
  - 0x9 with velocity != 0: ready=1 for one cycle, key_index=byte1, velocity=byte2.
  - 0x9 with velocity 0, or 0x8: note_off=1 for one cycle, key_index=byte1, velocity=0.
  - Other types: no event.
- Outputs:
  - ready and note_off are never high simultaneously.
  - key_index and velocity are registered and hold until the next event.
- Latency: the event pulse rises exactly 2 clocks after the clock edge that samples the stop bit of the final data byte.
- Throughput: back-to-back bytes (no idle time) must be received without loss.

Test Plan:
- Bytes 0x90,0x3C,0x64 at 2080 clk/bit -> one ready pulse 2 clocks after the 3rd stop-bit sample; key_index=60, velocity=100; note_off stays 0; frame_err=0.
- Running status 0x90,0x3C,0x64,0x40,0x00 -> ready (key 60, vel 100), then one note_off with key_index=64, velocity=0.
- 0x90,0x3C,0xF8,0x64 (realtime byte mid-message) -> single ready, key 60, vel 100. Then 0xF0,0x3C,0x64 -> no event.
- serial low for 500 clocks, then high -> no byte, no event. Then 0x80,0x30 with the stop bit held low -> frame_err=1, no event; a following 0x30,0x00 produces nothing (running status cleared).
- CHANNEL_FILTER=1, CHANNEL=0: 0x91,0x3C,0x64 -> no event. Then 0x90,0x3C,0x64 -> ready.
- reset_n pulsed low during the DATA bits of a velocity byte -> all outputs 0 immediately (asynchronous). A subsequent full 0x90,0x45,0x7F -> ready, key 69, vel 127.
